// File: rtl/jump_sprite_ctrl.sv
// jump_sprite_ctrl: frame-stepped jump/duck FSM with parabolic lift and a 2-stage sprite pixel pipeline
module jump_sprite_ctrl #(
  parameter int JUMP_FRAMES = 60,
  parameter int HEIGHT_DIV  = 6,
  parameter int GROUND_Y    = 402,
  parameter int SPRITE_X    = 80,
  parameter int SPRITE_W    = 82,
  parameter int STAND_H     = 88,
  parameter int DUCK_H      = 52
) (
  input  logic        clk,
  input  logic        RESET_N,
  input  logic        fresh,
  input  logic        game_status,
  input  logic        START,
  input  logic        button_jump,
  input  logic        button_duck,
  input  logic [8:0]  row_addr,
  input  logic [9:0]  col_addr,
  output logic [12:0] sprite_addr,
  output logic        sprite_sel,
  input  logic        sprite_bit,
  output logic        px,
  output logic [11:0] height,
  output logic        airborne,
  output logic [1:0]  state
);
  typedef enum logic [1:0] {IDLE = 2'd0, AIR = 2'd1, DUCK = 2'd2} state_t;
  state_t r_state, w_state_nx;
  logic r_fresh_s1, r_fresh_s2, r_fresh_d, w_tick;
  logic [7:0] r_t, w_t_nx;
  logic [8:0] w_t_adv;
  logic [15:0] w_t16, w_num;
  logic signed [15:0] w_row, w_col, w_bot, w_top, w_h;
  logic w_in_box, r_in_box;
  logic [12:0] w_addr;
  assign w_tick  = r_fresh_d & ~r_fresh_s2;
  assign w_t_adv = {1'b0, r_t} + (button_duck ? 9'd2 : 9'd1);
  assign state   = r_state;
  always_comb begin
    w_state_nx = r_state;
    w_t_nx = r_t;
    if (w_tick && game_status) begin
      case (r_state)
        IDLE: begin
          if (button_jump) begin
            w_state_nx = AIR;
            w_t_nx = 8'd1;
          end else if (button_duck) w_state_nx = DUCK;
        end
        DUCK: begin
          if (button_jump) begin
            w_state_nx = AIR;
            w_t_nx = 8'd1;
          end else if (!button_duck) w_state_nx = IDLE;
        end
        AIR: begin
          if (w_t_adv >= 9'(JUMP_FRAMES)) begin
            w_state_nx = IDLE;
            w_t_nx = '0;
          end else w_t_nx = w_t_adv[7:0];
        end
        default: begin
          w_state_nx = IDLE;
          w_t_nx = '0;
        end
      endcase
    end else if (w_tick && START) begin
      w_state_nx = IDLE;
      w_t_nx = '0;
    end
  end
  // Lift is t*(JUMP_FRAMES - t)/HEIGHT_DIV in 16-bit unsigned arithmetic
  assign w_t16 = {8'd0, r_t};
  assign w_num = w_t16 * 16'(JUMP_FRAMES) - w_t16 * w_t16;
  assign w_row = {7'd0, row_addr};
  assign w_col = {6'd0, col_addr};
  assign w_h   = (r_state == DUCK) ? 16'(DUCK_H) : 16'(STAND_H);
  assign w_bot = 16'(GROUND_Y) - {4'd0, height};
  assign w_top = w_bot - w_h;
  assign w_in_box = (w_row >= w_top) && (w_row < w_bot) &&
                    (w_col >= 16'(SPRITE_X)) && (w_col < 16'(SPRITE_X + SPRITE_W));
  assign w_addr = 13'((16'(SPRITE_X + SPRITE_W - 1) - w_col) + (w_row - w_top) * 16'(SPRITE_W));
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      r_fresh_s1  <= 1'b0;
      r_fresh_s2  <= 1'b0;
      r_fresh_d   <= 1'b0;
      r_state     <= IDLE;
      r_t         <= '0;
      airborne    <= 1'b0;
      sprite_sel  <= 1'b0;
      height      <= '0;
      r_in_box    <= 1'b0;
      sprite_addr <= '0;
      px          <= 1'b0;
    end else begin
      r_fresh_s1  <= fresh;
      r_fresh_s2  <= r_fresh_s1;
      r_fresh_d   <= r_fresh_s2;
      r_state     <= w_state_nx;
      r_t         <= w_t_nx;
      airborne    <= (w_state_nx == AIR);
      sprite_sel  <= (w_state_nx == DUCK);
      height      <= (r_t == '0) ? '0 : 12'(w_num / 16'(HEIGHT_DIV));
      r_in_box    <= w_in_box;
      sprite_addr <= w_in_box ? w_addr : '0;
      px          <= r_in_box & sprite_bit;
    end
  end
endmodule

// File: tb/tb_jump_sprite_ctrl.sv
// tb_jump_sprite_ctrl: directed stimulus with a frame-level behavioural model checked every settled cycle
module tb_jump_sprite_ctrl;
  logic clk = 0, RESET_N = 0, fresh = 1, game_status = 1, START = 0;
  logic button_jump = 0, button_duck = 0, sprite_bit = 0;
  logic [8:0] row_addr = '0;
  logic [9:0] col_addr = '0;
  logic [12:0] sprite_addr;
  logic sprite_sel, px, airborne;
  logic [11:0] height;
  logic [1:0] state;
  int total = 0, bad = 0;
  int m_state = 0, m_t = 0;
  bit settled = 0;

  always #5 clk = ~clk;

  jump_sprite_ctrl dut (
    .clk(clk), .RESET_N(RESET_N), .fresh(fresh), .game_status(game_status), .START(START),
    .button_jump(button_jump), .button_duck(button_duck), .row_addr(row_addr), .col_addr(col_addr),
    .sprite_addr(sprite_addr), .sprite_sel(sprite_sel), .sprite_bit(sprite_bit), .px(px),
    .height(height), .airborne(airborne), .state(state)
  );

  task automatic chk(string n, int a, int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", n, a, e);
    end
  endtask

  function automatic int m_height();
    return (m_t == 0) ? 0 : ((m_t * 60 - m_t * m_t) / 6) % 4096;
  endfunction

  function automatic int m_addr(int row, int col);
    int bot, top;
    bot = 402 - m_height();
    top = bot - ((m_state == 2) ? 52 : 88);
    if (row >= top && row < bot && col >= 80 && col < 162) return (161 - col) + (row - top) * 82;
    return -1;
  endfunction

  function automatic void model_step();
    int nt;
    if (game_status) begin
      if (m_state == 0) begin
        if (button_jump) begin m_state = 1; m_t = 1; end
        else if (button_duck) m_state = 2;
      end else if (m_state == 2) begin
        if (button_jump) begin m_state = 1; m_t = 1; end
        else if (!button_duck) m_state = 0;
      end else begin
        nt = m_t + (button_duck ? 2 : 1);
        if (nt >= 60) begin m_state = 0; m_t = 0; end
        else m_t = nt;
      end
    end else if (START) begin
      m_state = 0;
      m_t = 0;
    end
  endfunction

  always @(negedge clk) if (settled) begin
    chk("state", state, m_state);
    chk("height", height, m_height());
    chk("airborne", airborne, m_state == 1);
    chk("sprite_sel", sprite_sel, m_state == 2);
  end

  task automatic tick(int n = 1);
    for (int i = 0; i < n; i++) begin
      settled = 0;
      fresh = 0;
      repeat (6) @(posedge clk);
      model_step();
      fresh = 1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      settled = 1;
    end
  endtask

  task automatic scan(string n, int row, int col, bit b, int ea, int ep);
    int ma;
    row_addr = 9'(row);
    col_addr = 10'(col);
    @(negedge clk);
    ma = m_addr(row, col);
    chk({n, "_model_addr"}, (ma < 0) ? 0 : ma, ea);
    chk({n, "_addr"}, sprite_addr, ea);
    sprite_bit = b;
    @(negedge clk);
    chk({n, "_model_px"}, (ma >= 0) && b, ep);
    chk({n, "_px"}, px, ep);
  endtask

  task automatic chk_all_zero(string n);
    chk({n, "_state"}, state, 0);
    chk({n, "_height"}, height, 0);
    chk({n, "_px"}, px, 0);
    chk({n, "_addr"}, sprite_addr, 0);
    chk({n, "_sel"}, sprite_sel, 0);
    chk({n, "_air"}, airborne, 0);
  endtask

  initial begin
    row_addr = 9'd300;
    col_addr = 10'd100;
    sprite_bit = 1;
    #12 chk_all_zero("reset");
    #10 RESET_N = 1;
    @(negedge clk);
    settled = 1;
    repeat (3) @(negedge clk);
    scan("stand_r314", 314, 80, 1, 81, 1);
    scan("stand_bit0", 314, 80, 0, 81, 0);
    scan("col162", 314, 162, 1, 0, 0);
    scan("col161", 314, 161, 1, 0, 1);
    scan("row313", 313, 80, 1, 0, 0);
    scan("row401", 401, 80, 1, 7215, 1);
    button_jump = 1;
    tick();
    button_jump = 0;
    chk("h_t1", height, 9);
    chk("model_h_t1", m_height(), 9);
    chk("air_t1", airborne, 1);
    tick(29);
    chk("h_t30", height, 150);
    chk("model_h_t30", m_height(), 150);
    tick(29);
    chk("state_t59", state, 1);
    tick();
    chk("land60_state", state, 0);
    chk("land60_h", height, 0);
    button_jump = 1;
    tick();
    button_jump = 0;
    tick(9);
    button_duck = 1;
    tick();
    chk("ff_t12_h", height, 96);
    tick(23);
    chk("ff_t58_state", state, 1);
    chk("ff_t58_h", height, 19);
    tick();
    chk("ff_land35", state, 0);
    chk("ff_land35_h", height, 0);
    tick();
    chk("duck_state", state, 2);
    chk("duck_sel", sprite_sel, 1);
    scan("duck_r350", 350, 80, 1, 81, 1);
    scan("duck_r349", 349, 80, 1, 0, 0);
    scan("duck_r401", 401, 80, 1, 4263, 1);
    scan("duck_r402", 402, 80, 1, 0, 0);
    button_jump = 1;
    tick();
    chk("duck_jump_state", state, 1);
    chk("duck_jump_sel", sprite_sel, 0);
    chk("duck_jump_h", height, 9);
    scan("air_top", 305, 80, 1, 81, 1);
    scan("air_above", 304, 80, 1, 0, 0);
    button_jump = 0;
    button_duck = 0;
    tick(59);
    chk("land_after_duck", state, 0);
    button_jump = 1;
    tick();
    button_jump = 0;
    tick(6);
    chk("pause_pre_h", height, 61);
    game_status = 0;
    tick(5);
    chk("pause_h", height, 61);
    chk("pause_state", state, 1);
    START = 1;
    tick();
    START = 0;
    game_status = 1;
    chk("start_state", state, 0);
    chk("start_h", height, 0);
    button_jump = 1;
    tick();
    button_jump = 0;
    tick(4);
    chk("mid_h_t5", height, 45);
    row_addr = 9'd300;
    col_addr = 10'd100;
    sprite_bit = 1;
    @(negedge clk);
    @(negedge clk);
    chk("mid_addr", sprite_addr, 2603);
    chk("model_mid_addr", m_addr(300, 100), 2603);
    chk("mid_px", px, 1);
    settled = 0;
    #2 RESET_N = 0;
    #1 chk_all_zero("async_rst");
    #1 RESET_N = 1;
    m_state = 0;
    m_t = 0;
    button_jump = 1;
    @(negedge clk);
    settled = 1;
    repeat (10) @(negedge clk);
    chk("post_rst_hold", state, 0);
    tick();
    button_jump = 0;
    chk("post_rst_jump", state, 1);
    chk("post_rst_h", height, 9);
    settled = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/jump_sprite_ctrl.md
JUMP_SPRITE_CTRL -- requirements
Module: jump_sprite_ctrl

Interface
REQ-001 SHALL have parameter JUMP_FRAMES, default 60: frame ticks per full jump, range 2..254.
REQ-002 SHALL have parameter HEIGHT_DIV, default 6: divisor of the parabola numerator, range 1..15.
REQ-003 SHALL have parameter GROUND_Y, default 402: screen row just below the sprite feet.
REQ-004 SHALL have parameter SPRITE_X, default 80: left column of the sprite.
REQ-005 SHALL have parameter SPRITE_W, default 82: sprite width in pixels.
REQ-006 SHALL have parameter STAND_H, default 88: sprite height when standing or airborne.
REQ-007 SHALL have parameter DUCK_H, default 52: sprite height when ducking, and SHALL require DUCK_H <= STAND_H.
REQ-008 SHALL have ports clk (in, 1) and RESET_N (in, 1); the design uses one clock, and reset is asynchronous and active-low.
REQ-009 SHALL have ports fresh (in, 1) frame strobe, game_status (in, 1) 1=running, START (in, 1), button_jump (in, 1), and button_duck (in, 1).
REQ-010 SHALL have ports row_addr (in, 9) and col_addr (in, 10): the current scan pixel.
REQ-011 SHALL have port sprite_addr (out, 13): the sprite ROM bit index.
REQ-012 SHALL have ports sprite_sel (out, 1), where 0=stand ROM and 1=duck ROM, and sprite_bit (in, 1), the ROM data returned 1 cycle after sprite_addr.
REQ-013 SHALL have ports px (out, 1) sprite pixel, height (out, 12) current lift, airborne (out, 1), and state (out, 2).

Function
REQ-014 SHALL define frame_tick as a 1-cycle pulse on each falling edge of fresh, detected synchronously with a two-flop synchroniser plus edge register; fresh is not used as a clock.
REQ-015 SHALL implement states IDLE=0, AIR=1 and DUCK=2, with encoding 3 unused and recovering to IDLE on the next frame_tick.
REQ-016 SHALL evaluate all state and counter updates only on frame_tick with game_status=1; otherwise they hold.
REQ-017 In IDLE, on frame_tick, SHALL go to AIR with t=1 if button_jump=1, else SHALL go to DUCK if button_duck=1.
REQ-018 In DUCK, on frame_tick, SHALL go to AIR with t=1 if button_jump=1, else SHALL go to IDLE if button_duck=0; jump has priority over duck.
REQ-019 In AIR, on frame_tick, SHALL advance t by 1, or by 2 (fast-fall) while button_duck=1.
REQ-020 When the advanced t >= JUMP_FRAMES, SHALL set t=0 and go to IDLE with no overshoot frame.
REQ-021 SHALL ignore button_jump while in AIR (no double jump) and SHALL require the button to be held, not re-pressed, for retrigger.
REQ-022 SHALL compute height = (t*JUMP_FRAMES - t*t) / HEIGHT_DIV using unsigned 16-bit intermediates, truncated to 12 bits, registered 1 cycle after t changes.
REQ-023 SHALL drive height to 0 whenever t=0.
REQ-024 SHALL set airborne=1 exactly when state=AIR.
REQ-025 SHALL set sprite_sel=1 exactly when state=DUCK.
REQ-026 SHALL use H=DUCK_H when in DUCK, else STAND_H.
REQ-027 SHALL define top = GROUND_Y - height - H.
REQ-028 SHALL treat the sprite box as row in [top, GROUND_Y - height) and col in [SPRITE_X, SPRITE_X + SPRITE_W).
REQ-029 SHALL form the pixel pipeline stage 1 (registered) as in_box and sprite_addr = (SPRITE_X + SPRITE_W - 1 - col) + (row - top) * SPRITE_W; sprite_addr SHALL be 0 when not in_box.
REQ-030 SHALL form pixel pipeline stage 2 as px <= in_box_d & sprite_bit, giving total latency row/col -> px of 2 clk cycles.
REQ-031 SHALL apply state/height changes to the pixel path only at frame_tick boundaries, so there is no mid-frame tearing beyond the 1-cycle height register.
REQ-032 While game_status=0, SHALL clear state to IDLE and t to 0 on the next frame_tick if START=1; otherwise it holds, and the pixel path keeps rendering.

Reset
REQ-033 On RESET_N=0 (asynchronous), SHALL set state=IDLE, t=0, height=0, px=0, sprite_addr=0, sprite_sel=0, airborne=0, and clear synchroniser/edge/pipeline registers.
REQ-034 SHALL take effect immediately on reset assertion mid-jump; after release SHALL perform no action until the first frame_tick.
REQ-035 SHALL keep the sprite patterns external and SHALL not require them to be reloaded on reset.

Verification
REQ-036 Defaults, IDLE, button_jump held 1 tick then released -> state=AIR and t=1, height=9 after tick 1; height=150 at t=30; IDLE with height=0 on tick 60.
REQ-037 Jump with button_duck=1 from t=10 onward -> t sequence 10, 12, 14 …; lands at t>=60 on the 35th tick, not overshooting.
REQ-038 IDLE, button_duck=1 -> DUCK and sprite_sel=1; box rows 350..401; button_jump while ducking -> AIR with STAND_H=88.
REQ-039 Scan row=314, col=80 at height=0 -> sprite_addr=81 one cycle later; px equals the sprite_bit supplied, with 2-cycle latency; col=162 -> px=0.
REQ-040 Mid-jump, game_status=0 for 5 ticks -> t and height frozen; START=1 on a tick while paused -> IDLE with t=0.
REQ-041 RESET_N pulsed low asynchronously mid-jump between clk edges -> all outputs 0 before the next clk edge; no state change until the next fresh falling edge.
